// File: rtl/sc_pkg.sv
// sc_pkg: shared LFSR tap table, FSM states and seed rotation for stochastic number generators
package sc_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    // Galois (right-shift) feedback masks giving maximal-length sequences
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0E08;
            13:      return 16'h1C80;
            14:      return 16'h3802;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    // rotate the low w bits of v left by n; bits above w come back as 0
    function automatic logic [15:0] rotl(input logic [15:0] v, input int w, input int n);
        logic [15:0] m;
        int k;
        m = 16'((32'd1 << w) - 32'd1);
        k = n % w;
        return ((v << k) | ((v & m) >> (w - k))) & m;
    endfunction

endpackage

// File: rtl/sc_lfsr_load.sv
// sc_lfsr_load: Galois maximal-length LFSR with synchronous load, step enable and zero-seed guard
module sc_lfsr_load
    import sc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    // load wins over stepping; an all-zero seed would lock the register, so it becomes 1
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= WIDTH'(1);
        else if (load) q <= (seed == '0) ? WIDTH'(1) : seed;
        else if (en) q <= (q >> 1) ^ (q[0] ? TAPS : '0);

endmodule

// File: rtl/sng_array.sv
// sng_array: multi-channel stochastic number generator with start/busy/done stream-length handshake
module sng_array
    import sc_pkg::*;
#(
    parameter int PRECISION = 8,
    parameter int CHANNELS  = 4,
    parameter int LEN_W     = 16,
    parameter bit INDEP_RNG = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic [LEN_W-1:0]              len,
    input  logic [PRECISION-1:0]          seed,
    input  logic [CHANNELS*PRECISION-1:0] in,
    output logic                          busy,
    output logic                          out_valid,
    output logic [CHANNELS-1:0]           out,
    output logic                          done
);

    state_t                        state, state_nx;
    logic [LEN_W-1:0]              cnt;
    logic [CHANNELS*PRECISION-1:0] in_q;
    logic [PRECISION-1:0]          rng [CHANNELS];
    logic [PRECISION-1:0]          seed_nz;
    logic [CHANNELS-1:0]           cmp;
    logic                          accept, run, last;

    assign accept  = state == IDLE && start;
    assign run     = state == RUN;
    assign last    = run && !stop && cnt == LEN_W'(1);
    assign busy    = run;
    assign seed_nz = (seed == '0) ? PRECISION'(1) : seed;

    if (INDEP_RNG) begin : g_indep
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            sc_lfsr_load #(.WIDTH(PRECISION)) u_lfsr (
                .clk  (clk),
                .rst  (rst),
                .load (accept),
                .en   (run),
                .seed (PRECISION'(rotl(16'(seed_nz), PRECISION, c))),
                .q    (rng[c])
            );
        end
    end else begin : g_shared
        logic [PRECISION-1:0] q;
        sc_lfsr_load #(.WIDTH(PRECISION)) u_lfsr (
            .clk  (clk),
            .rst  (rst),
            .load (accept),
            .en   (run),
            .seed (seed_nz),
            .q    (q)
        );
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            assign rng[c] = q;
        end
    end

    // a channel emits 1 when its noise sample does not exceed the latched value
    always_comb begin
        cmp = '0;
        for (int i = 0; i < CHANNELS; i++)
            cmp[i] = rng[i] <= in_q[i*PRECISION +: PRECISION];
    end

    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    // IDLE -> RUN on a non-empty request; RUN -> IDLE on stop or after the final bit
    always_comb begin
        state_nx = state;
        if (!run) state_nx = (accept && len != '0) ? RUN : IDLE;
        else state_nx = (stop || cnt == LEN_W'(1)) ? IDLE : RUN;
    end

    // latch the request, count bits down (never past 0) and register the stream outputs
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt       <= '0;
            in_q      <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            done      <= 1'b0;
        end else begin
            if (accept) begin
                in_q <= in;
                cnt  <= len;
            end else if (run && cnt != '0) cnt <= cnt - LEN_W'(1);
            out_valid <= run && !stop;
            out       <= (run && !stop) ? cmp : '0;
            done      <= (accept && len == '0) || last;
        end

endmodule
